lcg_stim_gen: RTL and testbench

- Synthesizable stimulus source that sits directly upstream of the fuzzed `top` and drives its 266-bit `in_flat` input.
- Reproduces the bench's 32-bit LCG sequence bit-exactly, so hardware-in-loop and emulation runs match simulator logs for the same seed.
- Each vector is built from consecutive 32-bit LCG words, LSB word first; the final word is truncated.
- Vectors are delivered over a valid/ready handshake, and a counted run is bracketed by `start` and `done`.

---
 rtl/lcg_stim_gen_pkg.sv | 15 +
 rtl/lcg_stim_gen_if.sv | 10 +
 rtl/lcg_stim_gen_lcg32_step.sv | 10 +
 rtl/lcg_stim_gen.sv | 108 ++++++++++
 tb/tb_lcg_stim_gen.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/lcg_stim_gen_pkg.sv
// Shared constants, helpers and state encoding for the LCG stimulus source.
package stim_pkg;

  localparam logic [31:0] LCG_MULT     = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC      = 32'h3039;
  localparam logic [31:0] DEFAULT_SEED = 32'hDD56CC94;

  // Number of 32-bit LCG words needed to cover a w-bit vector.
  function automatic int nwords(int w);
    return (w + 31) / 32;
  endfunction

  typedef enum logic [1:0] {IDLE, FILL, PRESENT, DONE} stim_state_t;

endpackage

// File: rtl/lcg_stim_gen_if.sv
// Vector stream from the stimulus source to the fuzzed block.
interface lcg_stim_gen_if #(parameter int OUT_W = 266);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      vec_idx;

  modport master (output out_data, out_valid, vec_idx, input out_ready);
  modport slave  (input out_data, out_valid, vec_idx, output out_ready);
endinterface

// File: rtl/lcg_stim_gen_lcg32_step.sv
// One step of a 32-bit LCG; low 32 bits of s*MULT + INC.
module lcg32_step #(
  parameter logic [31:0] MULT = 32'h41C64E6D,
  parameter logic [31:0] INC  = 32'h3039
) (
  input  logic [31:0] s,
  output logic [31:0] s_next
);
  assign s_next = s * MULT + INC;
endmodule

// File: rtl/lcg_stim_gen.sv
// Builds OUT_W-bit vectors from consecutive LCG words (LSB word first) and
// streams them over a valid/ready handshake for a counted run.
module lcg_stim_gen #(
  parameter int          OUT_W        = 266,
  parameter logic [31:0] LCG_MULT     = stim_pkg::LCG_MULT,
  parameter logic [31:0] LCG_INC      = stim_pkg::LCG_INC,
  parameter logic [31:0] DEFAULT_SEED = stim_pkg::DEFAULT_SEED
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 seed_ovr,
  input  logic [31:0]          seed,
  input  logic [31:0]          num_vec,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  lcg_stim_gen_if.master       stim
);
  import stim_pkg::*;

  localparam int NWORDS    = nwords(OUT_W);
  localparam int LAST_BASE = 32 * (NWORDS - 1);
  localparam int LAST_W    = OUT_W - LAST_BASE;
  localparam int WIDX      = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [WIDX-1:0] LAST_IDX = WIDX'(NWORDS - 1);

  stim_state_t      state, state_d;
  logic [31:0]      rng, rng_next, remaining, vec_idx;
  logic [WIDX-1:0]  word_idx;
  logic [OUT_W-1:0] data;
  logic             start_ok, last_word, hs, out_valid;

  lcg32_step #(.MULT(LCG_MULT), .INC(LCG_INC)) u_step (.s(rng), .s_next(rng_next));

  // start is only honoured when no run is in flight, and abort beats it
  assign start_ok  = start && !abort && (state == IDLE || state == DONE);
  assign last_word = (state == FILL) && (word_idx == LAST_IDX);
  assign hs        = (state == PRESENT) && stim.out_ready;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state;
    if (abort) state_d = IDLE;
    else begin
      case (state)
        IDLE, DONE: if (start_ok) state_d = (num_vec != 32'd0) ? FILL : DONE;
        FILL:       if (last_word) state_d = PRESENT;
        PRESENT:    if (hs) state_d = (remaining != 32'd0) ? FILL : DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  // status outputs decode straight from state so reset drops them at once
  always_comb begin
    out_valid = (state == PRESENT);
    busy      = (state == FILL) || (state == PRESENT);
    done      = (state == DONE);
  end

  // datapath: seed load, per-word fill, run bookkeeping; abort freezes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rng       <= '0;
      remaining <= '0;
      vec_idx   <= '0;
      word_idx  <= '0;
      data      <= '0;
    end else if (!abort) begin
      case (state)
        IDLE, DONE: if (start_ok) begin
          rng       <= seed_ovr ? seed : DEFAULT_SEED;
          remaining <= num_vec;
          vec_idx   <= '0;
          word_idx  <= '0;
        end
        FILL: begin
          rng      <= rng_next;
          word_idx <= word_idx + 1'b1;
          for (int k = 0; k < NWORDS - 1; k++)
            if (word_idx == WIDX'(k)) data[32*k +: 32] <= rng_next;
          // final word is truncated to the bits left over
          if (word_idx == LAST_IDX) begin
            data[LAST_BASE +: LAST_W] <= rng_next[LAST_W-1:0];
            remaining <= remaining - 32'd1;
          end
        end
        PRESENT: if (hs && remaining != 32'd0) begin
          vec_idx  <= vec_idx + 32'd1;
          word_idx <= '0;
        end
        default: ;
      endcase
    end
  end

  assign stim.out_data  = data;
  assign stim.out_valid = out_valid;
  assign stim.vec_idx   = vec_idx;

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Randomized self-checking bench for lcg_stim_gen against an arithmetic LCG model.
module tb_lcg_stim_gen;
  localparam int OUT_W = 266;
  localparam int NW    = 9;
  typedef logic [OUT_W-1:0] vec_t;

  logic        clk = 1'b0;
  logic        rst, start, seed_ovr, abort, busy, done;
  logic [31:0] seed, num_vec;

  lcg_stim_gen_if #(.OUT_W(OUT_W)) stim ();

  lcg_stim_gen #(.OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .seed_ovr(seed_ovr), .seed(seed),
    .num_vec(num_vec), .abort(abort), .busy(busy), .done(done), .stim(stim.master)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_pass = 0;
  vec_t first_vec;

  task automatic chk(input string tag, input vec_t act, input vec_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, act, exp);
  endtask

  function automatic logic [31:0] lcg(input logic [31:0] s);
    return s * 32'h41C64E6D + 32'h3039;
  endfunction

  // one counted run; stall0 holds ready low on vector 0, rnd stalls randomly
  task automatic run(input bit ovr, input logic [31:0] sd, input int nv,
                     input int stall0, input bit rnd);
    logic [31:0]        s;
    logic [NW*32-1:0]   full;
    vec_t               exp;
    int                 cnt, st;
    s = ovr ? sd : 32'hDD56CC94;
    stim.out_ready = 1'b1;
    seed_ovr = ovr; seed = ovr ? sd : $urandom(); num_vec = nv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; seed = $urandom(); num_vec = $urandom();
    for (int v = 0; v < nv; v++) begin
      for (int k = 0; k < NW; k++) begin
        s = lcg(s);
        full[32*k +: 32] = s;
      end
      exp = full[OUT_W-1:0];
      st = rnd ? int'($urandom_range(0, 3)) : ((v == 0) ? stall0 : 0);
      if (st > 0) stim.out_ready = 1'b0;
      cnt = 0;
      while (!stim.out_valid && cnt < 40) begin
        @(negedge clk);
        cnt++;
      end
      chk("latency", vec_t'(cnt), vec_t'(9));
      chk("data", stim.out_data, exp);
      chk("top_bits", vec_t'(stim.out_data[265:256]), vec_t'(s[9:0]));
      chk("vec_idx", vec_t'(stim.vec_idx), vec_t'(v));
      chk("busy", vec_t'(busy), vec_t'(1));
      if (v == 0) first_vec = stim.out_data;
      for (int i = 0; i < st; i++) begin
        @(negedge clk);
        chk("hold_valid", vec_t'(stim.out_valid), vec_t'(1));
        chk("hold_data", stim.out_data, exp);
        chk("hold_idx", vec_t'(stim.vec_idx), vec_t'(v));
      end
      stim.out_ready = 1'b1;
      @(negedge clk);
      chk("valid_drop", vec_t'(stim.out_valid), vec_t'(0));
      chk("done", vec_t'(done), vec_t'(v == nv - 1));
    end
  endtask

  initial begin
    int cnt;
    rst = 1'b1; start = 1'b0; abort = 1'b0; seed_ovr = 1'b0;
    seed = '0; num_vec = '0; stim.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", vec_t'(stim.out_valid), vec_t'(0));
    chk("rst_data", stim.out_data, vec_t'(0));
    chk("rst_idx", vec_t'(stim.vec_idx), vec_t'(0));
    chk("rst_busy", vec_t'(busy), vec_t'(0));
    chk("rst_done", vec_t'(done), vec_t'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", vec_t'(busy), vec_t'(0));

    // known seed-0 vector
    run(1'b1, 32'h0, 1, 0, 1'b0);
    chk("seed0_w0", vec_t'(first_vec[31:0]), vec_t'(32'h00003039));
    chk("seed0_w1", vec_t'(first_vec[63:32]), vec_t'(32'hD3DC167E));

    // default seed, three back-to-back vectors
    run(1'b0, $urandom(), 3, 0, 1'b0);

    // long stall on the first vector
    run(1'b1, $urandom(), 2, 20, 1'b0);

    // zero-length run
    seed_ovr = 1'b0; num_vec = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("nv0_done", vec_t'(done), vec_t'(1));
    chk("nv0_busy", vec_t'(busy), vec_t'(0));
    repeat (3) begin
      @(negedge clk);
      chk("nv0_valid", vec_t'(stim.out_valid), vec_t'(0));
    end

    // abort during FILL, then start+abort together
    seed_ovr = 1'b1; seed = 32'h0; num_vec = 1; stim.out_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort_fill_busy", vec_t'(busy), vec_t'(1));
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", vec_t'(busy), vec_t'(0));
    chk("abort_valid", vec_t'(stim.out_valid), vec_t'(0));
    chk("abort_done", vec_t'(done), vec_t'(0));
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (2) begin
      chk("start_abort_busy", vec_t'(busy), vec_t'(0));
      chk("start_abort_done", vec_t'(done), vec_t'(0));
      @(negedge clk);
    end
    run(1'b1, 32'h0, 1, 0, 1'b0);
    chk("post_abort_w0", vec_t'(first_vec[31:0]), vec_t'(32'h00003039));

    // randomized runs with random back-pressure
    for (int r = 0; r < 6; r++)
      run(1'($urandom_range(0, 1)), $urandom(), int'($urandom_range(1, 4)), 0, 1'b1);

    // reset while a vector is presented
    seed_ovr = 1'b1; seed = $urandom(); num_vec = 2; stim.out_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!stim.out_valid && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("pre_rst_valid", vec_t'(stim.out_valid), vec_t'(1));
    #1 rst = 1'b1;
    #1;
    chk("async_valid", vec_t'(stim.out_valid), vec_t'(0));
    chk("async_busy", vec_t'(busy), vec_t'(0));
    chk("async_done", vec_t'(done), vec_t'(0));
    chk("async_data", stim.out_data, vec_t'(0));
    @(negedge clk);
    rst = 1'b0; stim.out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_idle", vec_t'({busy, done, stim.out_valid}), vec_t'(0));
    end
    run(1'b0, 32'h0, 2, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
